ustx_burst: RTL

Ultrasonic transmit burst sequencer for the four-transducer wind sensor. It fires 40 kHz square-wave bursts on one transducer at a time, in the fixed order uwX, dwX, uwY, dwY. After each burst it opens a listen window and indicates which opposite receiver the signal path must sample. It runs from the 2 MHz system clock and is the transmit-side counterpart of the receive processing chain (`winddirectionXY`).

---
 rtl/ustx_pkg.sv | 20 ++
 rtl/ustx_sqwave.sv | 68 ++++++
 rtl/ustx_burst.sv | 107 ++++++++++
 3 files changed

// File: rtl/ustx_pkg.sv
// Shared constants for the ultrasonic transmit burst sequencer: FSM state codes,
// phase-to-transducer maps and the default timing parameters.
package ustx_pkg;

  localparam int USTX_HALFPER  = 25;
  localparam int USTX_GUARDLEN = 100;
  localparam int USTX_DEADTIME = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_BURST  = 2'd1;
  localparam state_t ST_GUARD  = 2'd2;
  localparam state_t ST_LISTEN = 2'd3;

  // Index is the phase; phase order is tx2->rx4, tx4->rx2, tx3->rx1, tx1->rx3.
  localparam logic [3:0] TX_MAP [4] = '{4'b0010, 4'b1000, 4'b0100, 4'b0001};
  localparam logic [3:0] RX_MAP [4] = '{4'b1000, 4'b0010, 4'b0001, 4'b0100};

endpackage

// File: rtl/ustx_sqwave.sv
// Square-wave generator for one excitation burst: half-period counter, level toggle,
// period count and optional dead-time gating (enabled by USTX_DEADTIME_EN).
module ustx_sqwave
  import ustx_pkg::*;
#(
  parameter int HALFPER  = USTX_HALFPER,
  parameter int DEADTIME = USTX_DEADTIME
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] burstlen,
  output logic       level,
  output logic       legp,
  output logic       legn,
  output logic       done
);

  localparam int HCW = ($clog2(HALFPER) > 0) ? $clog2(HALFPER) : 1;

`ifdef USTX_DEADTIME_EN
  localparam int DT_EFF = DEADTIME;
`else
  localparam int DT_EFF = 0 * DEADTIME;
`endif

  logic [HCW-1:0] hc;
  logic [4:0]     pc;
  logic [4:0]     bl_q;
  logic           active;
  logic           hc_wrap;
  logic           dt_ok;

  assign hc_wrap = (hc == HCW'(HALFPER - 1));
  // hc >= DT_EFF, written so a zero dead time does not form a constant compare
  assign dt_ok   = ({1'b0, hc} + (HCW + 1)'(1)) > (HCW + 1)'(DT_EFF);
  assign done    = active & hc_wrap & ~level & (pc == bl_q - 5'd1);
  assign legp    = active & dt_ok & level;
  assign legn    = active & dt_ok & ~level;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hc     <= '0;
      pc     <= '0;
      bl_q   <= 5'd1;
      level  <= 1'b0;
      active <= 1'b0;
    end else if (start) begin
      hc     <= '0;
      pc     <= '0;
      level  <= 1'b1;
      active <= 1'b1;
      bl_q   <= (burstlen == 5'd0) ? 5'd1 : burstlen;
    end else if (active) begin
      if (hc_wrap) begin
        hc    <= '0;
        level <= ~level;
        if (!level) begin
          pc <= pc + 5'd1;
          if (done) active <= 1'b0;
        end
      end else begin
        hc <= hc + HCW'(1);
      end
    end
  end

endmodule

// File: rtl/ustx_burst.sv
// Transmit burst sequencer: walks the four transducer phases through BURST, GUARD and
// LISTEN. Dead-time gating of the drive legs is enabled by defining USTX_DEADTIME_EN.
module ustx_burst
  import ustx_pkg::*;
#(
  parameter int HALFPER  = USTX_HALFPER,
  parameter int GUARDLEN = USTX_GUARDLEN,
  parameter int DEADTIME = USTX_DEADTIME
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [4:0]  burstlen,
  input  logic [11:0] listenlen,
  output logic [3:0]  txp,
  output logic [3:0]  txn,
  output logic [3:0]  rxsel,
  output logic        rxwin,
  output logic [1:0]  phase,
  output logic        seqdone
);

  state_t      state;
  logic [11:0] cnt;
  logic [11:0] ll_q;
  logic        start;
  logic        listen_end;
  logic        legp;
  logic        legn;
  logic        done;
  logic        level_unused;
  logic        in_burst;

  assign listen_end = (state == ST_LISTEN) && (cnt == ll_q - 12'd1);
  assign start      = ((state == ST_IDLE) && run) ||
                      (listen_end && ((phase != 2'd3) || run));

  ustx_sqwave #(
    .HALFPER  (HALFPER),
    .DEADTIME (DEADTIME)
  ) u_sqwave (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .burstlen (burstlen),
    .level    (level_unused),
    .legp     (legp),
    .legn     (legn),
    .done     (done)
  );

  // Burst length is latched by the square-wave block on the same start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      phase   <= 2'd0;
      cnt     <= '0;
      ll_q    <= 12'd1;
      seqdone <= 1'b0;
    end else begin
      seqdone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) state <= ST_BURST;
        end
        ST_BURST: begin
          if (done) begin
            state <= ST_GUARD;
            cnt   <= '0;
          end
        end
        ST_GUARD: begin
          if (cnt == 12'(GUARDLEN - 1)) begin
            state <= ST_LISTEN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        ST_LISTEN: begin
          if (listen_end) begin
            cnt <= '0;
            if (phase != 2'd3) begin
              phase <= phase + 2'd1;
              state <= ST_BURST;
            end else begin
              phase   <= 2'd0;
              seqdone <= 1'b1;
              state   <= run ? ST_BURST : ST_IDLE;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (start) ll_q <= (listenlen == 12'd0) ? 12'd1 : listenlen;
    end
  end

  assign in_burst = (state == ST_BURST);
  assign txp      = TX_MAP[phase] & {4{legp & in_burst}};
  assign txn      = TX_MAP[phase] & {4{legn & in_burst}};
  assign rxwin    = (state == ST_LISTEN);
  assign rxsel    = rxwin ? RX_MAP[phase] : 4'b0000;

endmodule
